// File: rtl/aes_ctr_feeder_if.sv
// Host-side bus of the AES-CTR feeder: message start, input stream, output stream, status.
interface aes_ctr_feeder_if #(
    parameter int unsigned CNT_W = 16
);
    logic             start;
    logic [127:0]     iv;
    logic [CNT_W-1:0] n_blocks;
    logic             in_valid;
    logic [127:0]     in_data;
    logic             in_ready;
    logic             out_valid;
    logic [127:0]     out_data;
    logic             busy;
    logic             done;

    modport master (
        output start, iv, n_blocks, in_valid, in_data,
        input  in_ready, out_valid, out_data, busy, done
    );

    modport slave (
        input  start, iv, n_blocks, in_valid, in_data,
        output in_ready, out_valid, out_data, busy, done
    );
endinterface

// File: rtl/aes_ctr_feeder.sv
// CTR-mode wrapper around a fully pipelined AES-128 core with no handshake of its own.
// Issues one counter block per accepted word and XORs the delayed word with the keystream.
module aes_ctr_feeder #(
    parameter int unsigned LAT   = 11,
    parameter int unsigned CTR_W = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    aes_ctr_feeder_if.slave     host,
    output logic [127:0]        aes_state,
    input  logic [127:0]        aes_out
);

    localparam int unsigned BLK_W = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [BLK_W-1:0] data;
    } dl_entry_t;

    state_t           state;
    state_t           state_nxt;
    logic [BLK_W-1:0] ctr;
    logic [CNT_W-1:0] blk_cnt;
    logic             in_ready_q;
    logic             busy_q;
    logic             done_q;
    logic             out_valid_q;
    logic [BLK_W-1:0] out_data_q;
    logic             accept_c;
    logic             load_c;
    logic             done_c;
    logic             line_busy_c;

    // Stage 0 is registered together with aes_state; stage LAT lines up with aes_out.
    dl_entry_t        dl [LAT+1];

    assign host.in_ready  = in_ready_q;
    assign host.busy      = busy_q;
    assign host.done      = done_q;
    assign host.out_valid = out_valid_q;
    assign host.out_data  = out_data_q;

    // Any block still travelling through the core.
    always_comb begin
        line_busy_c = 1'b0;
        for (int unsigned i = 0; i <= LAT; i++) begin
            line_busy_c = line_busy_c | dl[i].valid;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-cycle strobes.
    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        load_c    = 1'b0;
        done_c    = 1'b0;
        case (state)
            IDLE: begin
                if (host.start) begin
                    load_c    = 1'b1;
                    state_nxt = (host.n_blocks == '0) ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (host.in_valid && in_ready_q) begin
                    accept_c = 1'b1;
                    if (blk_cnt == CNT_W'(1)) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!line_busy_c) begin
                    done_c    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered status outputs, derived from the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            in_ready_q <= (state_nxt == RUN);
            busy_q     <= (state_nxt != IDLE);
            done_q     <= done_c;
        end
    end

    // Counter block, block count and core input; only the low CTR_W bits ever increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctr       <= '0;
            blk_cnt   <= '0;
            aes_state <= '0;
        end else if (load_c) begin
            ctr     <= host.iv;
            blk_cnt <= host.n_blocks;
        end else if (accept_c) begin
            aes_state        <= ctr;
            ctr[CTR_W-1:0]   <= ctr[CTR_W-1:0] + CTR_W'(1);
            blk_cnt          <= blk_cnt - CNT_W'(1);
        end
    end

    // Validity/data shadow of the core pipeline, advancing every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i <= LAT; i++) begin
                dl[i] <= '0;
            end
        end else begin
            dl[0].valid <= accept_c;
            dl[0].data  <= accept_c ? host.in_data : '0;
            for (int unsigned i = 1; i <= LAT; i++) begin
                dl[i] <= dl[i-1];
            end
        end
    end

    // Combine the delayed word with the keystream; data holds between valid outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= dl[LAT].valid;
            if (dl[LAT].valid) begin
                out_data_q <= dl[LAT].data ^ aes_out;
            end
        end
    end

endmodule
